// File: rtl/prt_dptx_vid_crc_pkg.sv
// Shared constants, payload layout and state encoding for the DP TX
// per-component video CRC / test-CRC SDP generator.
package prt_dptx_vid_crc_pkg;

    // CRC-16/BUYPASS: poly 0x8005, init 0, MSB first, no reflection, no final XOR
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

    // SDP payload geometry (bit offsets into the 320-bit header+data word)
    localparam int SDP_W      = 320;
    localparam int OFS_HB1    = 8;
    localparam int OFS_HB2    = 16;
    localparam int OFS_CRC    = 32;
    localparam int OFS_PIXCNT = 96;
    localparam int OFS_FRAME  = 128;

    typedef enum logic {
        S_WAIT  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    // One serial CRC step: shift in a single data bit, MSB-first
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/prt_dptx_crc16_par.sv
// CRC-16 for one colour channel over up to P_PPC pixels per clock.
// Dropped pixels (keep=0) are skipped entirely, so a sparse word gives the
// same CRC as the kept pixels sent one per clock. A clear in the same cycle
// as new data restarts from the init value and folds that data in at once.
module prt_dptx_crc16_par
    import prt_dptx_vid_crc_pkg::*;
#(
    parameter int P_PPC = 4,
    parameter int P_BPC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cke,
    input  logic                     clr,
    input  logic                     en,
    input  logic [P_PPC*P_BPC-1:0]   data,
    input  logic [P_PPC-1:0]         keep,
    output logic [15:0]              crc
);

    logic [15:0] crc_r;
    logic [15:0] crc_next_s;

    // Fold the kept pixels, lowest pixel index first, into the running CRC
    always_comb begin
        crc_next_s = clr ? CRC16_INIT : crc_r;
        for (int p = 0; p < P_PPC; p++) begin
            if (keep[p]) begin
                for (int b = P_BPC - 1; b >= 0; b--) begin
                    crc_next_s = crc16_bit(crc_next_s, data[p*P_BPC + b]);
                end
            end else begin
                crc_next_s = crc_next_s;
            end
        end
    end

    // CRC register: accumulate on enable, otherwise honour a bare clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_r <= CRC16_INIT;
        end else if (cke) begin
            if (en) begin
                crc_r <= crc_next_s;
            end else if (clr) begin
                crc_r <= CRC16_INIT;
            end
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/prt_dptx_vid_crc_sdp.sv
// Per-component video CRC engine with test-CRC SDP generation. Each vsync
// rising edge closes a frame: its CRCs, pixel count and frame number are
// latched into an SDP payload offered over valid/ready. A new frame arriving
// while the previous SDP is still unaccepted overwrites it and is counted.
module prt_dptx_vid_crc_sdp
    import prt_dptx_vid_crc_pkg::*;
#(
    parameter int          P_PPC      = 4,
    parameter int          P_CH       = 3,
    parameter int          P_BPC      = 16,
    parameter logic [7:0]  P_SDP_TYPE = 8'h20,
    parameter logic [7:0]  P_PROFILE  = 8'h00
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cke,
    input  logic                          cfg_en,
    input  logic                          vsync,
    input  logic [P_PPC*P_CH*P_BPC-1:0]   pix_data,
    input  logic [P_PPC-1:0]              pix_keep,
    input  logic                          pix_valid,
    output logic                          sdp_valid,
    input  logic                          sdp_ready,
    output logic [SDP_W-1:0]              sdp_payload,
    output logic [15:0]                   frame_cnt,
    output logic [7:0]                    ovf_cnt
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic               vsync_q_r;
    logic               vs_edge_s;
    logic               clr_s;
    logic               acc_s;
    logic               emit_s;
    logic [31:0]        keep_cnt_s;
    logic [31:0]        pix_cnt_r;
    logic [15:0]        frame_cnt_r;
    logic [7:0]         ovf_cnt_r;
    logic               sdp_valid_r;
    logic [SDP_W-1:0]   payload_r;
    logic [SDP_W-1:0]   payload_nxt_s;
    logic [15:0]        crc_s     [P_CH];
    logic [P_PPC*P_BPC-1:0] ch_data_s [P_CH];

    assign vs_edge_s = vsync & ~vsync_q_r;

    // Regroup the pixel word per channel and run one CRC engine per channel
    for (genvar c = 0; c < P_CH; c++) begin : g_ch
        for (genvar p = 0; p < P_PPC; p++) begin : g_px
            assign ch_data_s[c][p*P_BPC +: P_BPC] = pix_data[(p*P_CH + c)*P_BPC +: P_BPC];
        end
        prt_dptx_crc16_par #(
            .P_PPC (P_PPC),
            .P_BPC (P_BPC)
        ) u_crc (
            .clk  (clk),
            .rst  (rst),
            .cke  (cke),
            .clr  (clr_s),
            .en   (acc_s),
            .data (ch_data_s[c]),
            .keep (pix_keep),
            .crc  (crc_s[c])
        );
    end

    // Frame FSM: a word on the edge cycle already belongs to the new frame
    always_comb begin
        state_nxt_s = state_r;
        clr_s       = 1'b0;
        acc_s       = 1'b0;
        emit_s      = 1'b0;
        case (state_r)
            S_WAIT: begin
                if (vs_edge_s && cfg_en) begin
                    state_nxt_s = S_ACCUM;
                    clr_s       = 1'b1;
                    acc_s       = pix_valid;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_ACCUM: begin
                if (!cfg_en) begin
                    state_nxt_s = S_WAIT;
                    clr_s       = 1'b1;
                end else if (vs_edge_s) begin
                    emit_s      = 1'b1;
                    clr_s       = 1'b1;
                    acc_s       = pix_valid;
                end else begin
                    acc_s       = pix_valid;
                end
            end
            default: begin
                state_nxt_s = S_WAIT;
                clr_s       = 1'b1;
            end
        endcase
    end

    // Number of kept pixels in the current word
    always_comb begin
        keep_cnt_s = 32'd0;
        for (int p = 0; p < P_PPC; p++) begin
            keep_cnt_s = keep_cnt_s + {31'd0, pix_keep[p]};
        end
    end

    // Assemble the SDP for the frame that is closing
    always_comb begin
        payload_nxt_s = '0;
        payload_nxt_s[OFS_HB1 +: 8] = P_SDP_TYPE;
        payload_nxt_s[OFS_HB2 +: 8] = P_PROFILE;
        for (int c = 0; c < P_CH; c++) begin
            payload_nxt_s[OFS_CRC + 16*c +: 16] = crc_s[c];
        end
        payload_nxt_s[OFS_PIXCNT +: 32] = pix_cnt_r;
        payload_nxt_s[OFS_FRAME  +: 16] = frame_cnt_r;
    end

    // Edge-detect history and FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q_r <= 1'b0;
            state_r   <= S_WAIT;
        end else if (cke) begin
            vsync_q_r <= vsync;
            state_r   <= state_nxt_s;
        end
    end

    // Pixel counter, restarted together with the CRCs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_r <= 32'd0;
        end else if (cke) begin
            pix_cnt_r <= (clr_s ? 32'd0 : pix_cnt_r) + (acc_s ? keep_cnt_s : 32'd0);
        end
    end

    // Payload latch, frame counter and saturating overflow counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payload_r   <= '0;
            frame_cnt_r <= 16'd0;
            ovf_cnt_r   <= 8'd0;
        end else if (cke && emit_s) begin
            payload_r   <= payload_nxt_s;
            frame_cnt_r <= frame_cnt_r + 16'd1;
            if (sdp_valid_r && !sdp_ready && (ovf_cnt_r != 8'hFF)) begin
                ovf_cnt_r <= ovf_cnt_r + 8'd1;
            end
        end
    end

    // Valid: set by a new SDP, cleared by a handshake even when cke is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdp_valid_r <= 1'b0;
        end else if (cke && emit_s) begin
            sdp_valid_r <= 1'b1;
        end else if (sdp_valid_r && sdp_ready) begin
            sdp_valid_r <= 1'b0;
        end
    end

    assign sdp_valid   = sdp_valid_r;
    assign sdp_payload = payload_r;
    assign frame_cnt   = frame_cnt_r;
    assign ovf_cnt     = ovf_cnt_r;

endmodule

// File: doc/prt_dptx_vid_crc_sdp.md
Name: prt_dptx_vid_crc_sdp

Overview:
- Parametrised per-component video CRC engine and test-CRC SDP generator for the DP TX video path.
- Computes an independent CRC-16 for each colour component over all valid pixels of a frame. Pixels are packed P_PPC per clock.
- On each frame boundary (vsync rising edge) it packs the completed frame's CRCs, pixel count and frame number into an SDP payload. The payload is offered to the SDP mux over a valid/ready handshake.
- Supersedes the fixed single-CRC32 profile-0 path. Adds per-pixel keep, back-pressure, an overflow counter and an enable.

Parameters:
- P_PPC, 4, pixels per clock (1..8).
- P_CH, 3, colour components per pixel (1..4).
- P_BPC, 16, bits per component (6..16).
- P_SDP_TYPE, 8'h20, SDP header byte HB1.
- P_PROFILE, 8'h00, SDP header byte HB2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cke  in  1  clock enable; qualifies all sampling and state updates
- cfg_en  in  1  block enable
- vsync  in  1  vertical sync, level
- pix_data  in  P_PPC*P_CH*P_BPC  pixel p, component c at [(p*P_CH+c)*P_BPC +: P_BPC]
- pix_keep  in  P_PPC  per-pixel valid
- pix_valid  in  1  word valid
- sdp_valid  out  1  payload valid
- sdp_ready  in  1  payload accepted when valid&ready
- sdp_payload  out  320  SDP header+data
- frame_cnt  out  16  number of SDPs generated
- ovf_cnt  out  8  SDPs dropped, saturating

Behaviour:
- Reset values: sdp_valid=0, sdp_payload=0, frame_cnt=0, ovf_cnt=0, all CRCs=16'h0000, pixel count=0, vsync_q=0, state=S_WAIT.
- Qualification: all registers update only when cke=1, except sdp_valid clearing on handshake (valid&ready), which is not cke-qualified.
- Edge: vs_edge = vsync & ~vsync_q in a cke cycle. vsync_q <= vsync on cke.
- CRC algorithm: CRC-16, poly 0x8005, init 0x0000, MSB-first, non-reflected, no final XOR (CRC-16/BUYPASS).
- CRC feed order: per channel c, on a cycle with pix_valid&cke, bits of component c of pixel 0..P_PPC-1 are fed in ascending pixel order, MSB first. Pixels with pix_keep[p]=0 are skipped. Non-contiguous keep is legal.
- Pixel count: 32-bit, += popcount(pix_keep) per accepted word. Wraps at 2^32.
- State S_WAIT: ignore pixels. On vs_edge with cfg_en=1: clear CRCs and count, go to S_ACCUM. No SDP.
- State S_ACCUM: accumulate. On vs_edge:
  - latch payload from current CRCs/count/frame_cnt;
  - sdp_valid<=1;
  - frame_cnt++ (wraps 0xFFFF->0);
  - clear CRCs/count.
- Same-cycle edge and pixels: a pixel word in the same cycle as vs_edge belongs to the new frame. It is excluded from the latched CRC and is the first data of the new accumulation.
- Latency: sdp_valid asserted the cycle after the vs_edge cycle.
- Payload layout, all other bits zero:
  - [7:0]=8'h00, [15:8]=P_SDP_TYPE, [23:16]=P_PROFILE, [31:24]=8'h00;
  - [32+16*c +:16]=CRC of channel c (c<P_CH); unused channel slots up to 4 are zero;
  - [96 +:32]=pixel count;
  - [128 +:16]=frame_cnt before increment (first SDP carries 0).
- Handshake: payload stable while sdp_valid=1 and sdp_ready=0. valid&ready in a cycle without a new edge -> sdp_valid<=0 next cycle.
- Overflow: vs_edge while sdp_valid=1 and sdp_ready=0 -> payload overwritten with new frame, sdp_valid stays 1, ovf_cnt++ (saturate at 255). frame_cnt still increments.
- Simultaneous ready and edge: vs_edge with valid&ready -> old payload accepted, new payload loaded, sdp_valid stays 1, no overflow.
- Disable: cfg_en=0 in S_ACCUM -> return to S_WAIT next cke cycle and clear CRCs. A pending SDP remains valid until accepted.
- Reset mid-frame: everything returns to reset values asynchronously. The first post-reset edge only starts accumulation.

Decomposition:
- Package prt_dptx_vid_crc_pkg holds:
  - CRC16 polynomial and init constants;
  - payload field offsets (header, CRC base, pixel count, frame counter) and 320-bit payload width;
  - state enum {S_WAIT, S_ACCUM}.
- Sub-module prt_dptx_crc16_par:
  - one per channel;
  - combinational next-CRC over P_PPC keep-gated P_BPC-bit slices, plus CRC register with clear and enable.
- Top module holds the edge detector, FSM, counters and payload register.

Test Plan:
- CRC check value: P_PPC=1, P_CH=3, P_BPC=8; every channel gets ASCII "123456789" over 9 words, then vs_edge -> payload CRCs 0xFEE8/0xFEE8/0xFEE8, pixel count 9, frame field 0.
- First-edge suppression: after reset, first vs_edge produces no SDP. Second edge with 100 words (keep=4'hF) -> one SDP with pixel count 400, frame_cnt becomes 1.
- Keep handling: default params; single word with keep=4'b0101 equals CRC of two words keep=4'b0001 carrying pixel0 then pixel2 -> identical CRCs, pixel count 2.
- Back-pressure: hold sdp_ready=0 across 3 frame edges -> ovf_cnt=2, payload frame field=2, frame_cnt=3. Then raise ready -> one handshake, sdp_valid drops.
- Edge coincidence: pixel word and vs_edge in same cycle -> excluded from latched CRC, included in next frame's count. Ready and edge in same cycle -> ovf_cnt unchanged, sdp_valid stays 1.
- cke/reset: cke=0 with vsync toggling and pix_valid=1 -> no state change. Assert rst mid-frame with sdp_valid=1 -> all outputs 0 immediately.
